// File: rtl/aux_pkg.sv
// aux_pkg: shared state encoding and default sizes for the aux index counter
package aux_pkg;
  localparam int CNT_W_DEF  = 6;
  localparam int MAX_SZ_DEF = 32;
  localparam int STALL_W    = 8;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/aux_sat_cnt.sv
// aux_sat_cnt: up-counter that stops at a limit, with clear taking priority over enable
module aux_sat_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt
);
  // count up while enabled, never past the limit, so the value cannot wrap
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt < limit) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/aux_cnt_ctrl.sv
// aux_cnt_ctrl: latches a traversal size on start and steps an index to it, pulsing done or err
// Build option AUX_CNT_STALL_STAT_EN adds stall_cnt_o, a saturating count of stalled RUN cycles.
module aux_cnt_ctrl import aux_pkg::*; #(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MAX_SZ = MAX_SZ_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] sz_full_i,
  output logic [CNT_W-1:0] aux_reg_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef AUX_CNT_STALL_STAT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt_o
`endif
);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_SZ);
  state_e           state, nxt;
  logic [CNT_W-1:0] sz_q;
  logic             sz_ok, acc, rej, hit, idx_clr, idx_en;
  // start validation and next state; clr_i overrides every other request
  always_comb begin
    sz_ok   = sz_full_i != '0 && sz_full_i <= MAX_V;
    acc     = state == S_IDLE && start_i && !clr_i && sz_ok;
    rej     = state == S_IDLE && start_i && !clr_i && !sz_ok;
    hit     = state == S_RUN && en_i && aux_reg_o + CNT_W'(1) == sz_q;
    idx_clr = clr_i || state != S_RUN;
    idx_en  = state == S_RUN && en_i;
    nxt     = clr_i ? S_IDLE : acc ? S_RUN : hit ? S_DONE : state == S_DONE ? S_IDLE : state;
  end
  // state, latched size and registered status flags
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state  <= S_IDLE;
      sz_q   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= nxt;
      sz_q   <= acc ? sz_full_i : sz_q;
      busy_o <= nxt == S_RUN;
      done_o <= nxt == S_DONE;
      err_o  <= rej;
    end
  aux_sat_cnt #(.CNT_W(CNT_W)) u_idx (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (idx_clr),
    .en    (idx_en),
    .limit (sz_q),
    .cnt   (aux_reg_o)
  );
`ifdef AUX_CNT_STALL_STAT_EN
  aux_sat_cnt #(.CNT_W(STALL_W)) u_stall (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (acc),
    .en    (state == S_RUN && !en_i),
    .limit ({STALL_W{1'b1}}),
    .cnt   (stall_cnt_o)
  );
`endif
endmodule

// File: tb/tb_aux_cnt_ctrl.sv
// tb_aux_cnt_ctrl: directed and random stimulus checked against a behavioural traversal model
module tb_aux_cnt_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start_i = 1'b0, en_i = 1'b0, clr_i = 1'b0;
  logic [5:0] sz_full_i = '0;
  logic [5:0] aux_reg_o;
  logic       busy_o, done_o, err_o;
`ifdef AUX_CNT_STALL_STAT_EN
  logic [7:0] stall_cnt_o;
`endif
  int checks = 0, errors = 0;

  aux_cnt_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start_i),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .sz_full_i (sz_full_i),
    .aux_reg_o (aux_reg_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
`ifdef AUX_CNT_STALL_STAT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // reference: running flag, index, size, one-cycle done/err pulses, stall count
  bit m_run, m_done, m_err;
  int m_idx, m_sz, m_stall;
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      m_run <= 0; m_done <= 0; m_err <= 0; m_idx <= 0; m_sz <= 0; m_stall <= 0;
    end else begin
      m_done <= 0;
      m_err  <= 0;
      if (m_run && !en_i && m_stall < 255) m_stall <= m_stall + 1;
      if (clr_i) begin
        m_run <= 0;
        m_idx <= 0;
      end else if (m_run) begin
        if (en_i) begin
          m_idx <= m_idx + 1;
          if (m_idx + 1 == m_sz) begin m_run <= 0; m_done <= 1; end
        end
      end else if (m_done) m_idx <= 0;
      else if (start_i) begin
        if (sz_full_i >= 1 && sz_full_i <= 32) begin
          m_run <= 1; m_sz <= int'(sz_full_i); m_idx <= 0; m_stall <= 0;
        end else m_err <= 1;
      end
    end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle out of reset the DUT must match the model
  always @(negedge clk)
    if (rstn) begin
      chk("cmp_aux", int'(aux_reg_o), m_idx);
      chk("cmp_busy", int'(busy_o), int'(m_run));
      chk("cmp_done", int'(done_o), int'(m_done));
      chk("cmp_err", int'(err_o), int'(m_err));
`ifdef AUX_CNT_STALL_STAT_EN
      chk("cmp_stall", int'(stall_cnt_o), m_stall);
`endif
    end

  task automatic drive(input bit s, input bit e, input bit c, input int sz);
    start_i = s; en_i = e; clr_i = c; sz_full_i = 6'(sz);
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int strobes, zeros;
    bit got;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    chk("rst_aux", int'(aux_reg_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    // size 8, strobes every cycle
    drive(1, 0, 0, 8); cyc();
    chk("t1_start_aux", int'(aux_reg_o), 0);
    chk("t1_start_busy", int'(busy_o), 1);
    drive(0, 1, 0, 0);
    strobes = 1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("t1_aux", int'(aux_reg_o), i);
      chk("t1_done", int'(done_o), int'(i == 8));
      if (busy_o) strobes++;
    end
    chk("t1_busy_cycles", strobes, 8);
    drive(0, 0, 0, 0); cyc();
    chk("t1_after_aux", int'(aux_reg_o), 0);
    chk("t1_after_done", int'(done_o), 0);
    // size 32 with en pattern 1,0,0,1
    drive(1, 0, 0, 32); cyc();
    strobes = 0; zeros = 0; got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      drive(0, (k % 4 == 0) || (k % 4 == 3), 0, 0);
      cyc();
      if (en_i) strobes++; else zeros++;
      if (done_o) begin
        got = 1;
        chk("t2_strobes", strobes, 32);
        chk("t2_aux", int'(aux_reg_o), 32);
`ifdef AUX_CNT_STALL_STAT_EN
        chk("t2_stall", int'(stall_cnt_o), zeros);
`endif
      end
    end
    if (!got) chk("t2_done_seen", 0, 1);
    drive(0, 0, 0, 0); cyc();
    // rejected sizes
    drive(1, 0, 0, 0); cyc();
    chk("t3_err0", int'(err_o), 1);
    chk("t3_busy0", int'(busy_o), 0);
    drive(0, 0, 0, 0); cyc();
    chk("t3_err0_off", int'(err_o), 0);
    drive(1, 0, 0, 40); cyc();
    chk("t3_err40", int'(err_o), 1);
    chk("t3_aux40", int'(aux_reg_o), 0);
    drive(0, 0, 0, 0); cyc();
    chk("t3_busy40", int'(busy_o), 0);
    // clr together with en at index 5
    drive(1, 0, 0, 10); cyc();
    drive(0, 1, 0, 0); repeat (5) cyc();
    chk("t4_aux5", int'(aux_reg_o), 5);
    drive(0, 1, 1, 0); cyc();
    chk("t4_aux", int'(aux_reg_o), 0);
    chk("t4_busy", int'(busy_o), 0);
    chk("t4_done", int'(done_o), 0);
    drive(0, 0, 0, 0); cyc();
    chk("t4_done_next", int'(done_o), 0);
    // start ignored in RUN
    drive(1, 0, 0, 6); cyc();
    drive(0, 1, 0, 0); repeat (3) cyc();
    drive(1, 1, 0, 4); cyc();
    chk("t5_aux4", int'(aux_reg_o), 4);
    chk("t5_nodone4", int'(done_o), 0);
    chk("t5_busy4", int'(busy_o), 1);
    drive(0, 1, 0, 0); cyc(); cyc();
    chk("t5_aux6", int'(aux_reg_o), 6);
    chk("t5_done6", int'(done_o), 1);
    drive(0, 0, 0, 0); cyc();
    // asynchronous reset mid-RUN
    drive(1, 0, 0, 8); cyc();
    drive(0, 1, 0, 0); cyc(); cyc();
    #2 rstn = 1'b0;
    #1;
    chk("t6_aux", int'(aux_reg_o), 0);
    chk("t6_busy", int'(busy_o), 0);
    chk("t6_done", int'(done_o), 0);
    drive(0, 0, 0, 0);
    cyc();
    rstn = 1'b1;
    drive(1, 0, 0, 1); cyc();
    drive(0, 1, 0, 0); cyc();
    chk("t6_post_done", int'(done_o), 1);
    chk("t6_post_aux", int'(aux_reg_o), 1);
    drive(0, 0, 0, 0); cyc();
    // random traffic, compared every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0, int'($urandom_range(0, 63)));
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aux_cnt_ctrl.md
Name: aux_cnt_ctrl

Overview:
- Upstream auxiliary index counter for the matrix-traversal datapath.
- Drives aux_reg_o, the 6-bit running index consumed by the terminal-count comparator stage that signals the FSM.
- Latches the requested size on start and advances one step per datapath strobe.
- Saturates at the latched size, then pulses done and returns to idle.

Parameters:
- CNT_W, 6, width of the index counter and the size input.
- MAX_SZ, 32, largest legal size; larger requests are rejected.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start_i  in  1  begin a traversal; sampled only in IDLE.
- en_i  in  1  step strobe from the datapath; one increment per cycle high.
- clr_i  in  1  synchronous abort; returns the block to IDLE.
- sz_full_i  in  CNT_W  requested size; latched on accepted start.
- aux_reg_o  out  CNT_W  current index (registered).
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse on terminal count.
- err_o  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, aux_reg_o=0, sz_q=0, busy_o=0, done_o=0, err_o=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, RUN, DONE (2-bit encoding, constants in package).
- IDLE, start_i=1, sz_full_i in 1..MAX_SZ: latch sz_q, aux_reg_o=0, go to RUN. busy_o=1 from the next cycle.
- IDLE, start_i=1, sz_full_i==0 or >MAX_SZ: err_o pulses one cycle, stay in IDLE, sz_q unchanged.
- RUN, en_i=1, aux_reg_o<sz_q: aux_reg_o increments by 1 on the next edge.
- RUN, en_i=1 making aux_reg_o==sz_q: go to DONE. done_o=1 in that same registered cycle; busy_o=0.
- RUN, en_i=0: hold the index; stall length is unbounded.
- DONE: lasts exactly one cycle. aux_reg_o holds sz_q so the comparator sees the match for one cycle. Next state is IDLE with aux_reg_o=0.
- clr_i=1 in any state: next state IDLE, aux_reg_o=0, no done_o/err_o pulse.
- clr_i beats en_i and start_i when asserted simultaneously.
- start_i in RUN or DONE is ignored; no error is raised.
- en_i in IDLE or DONE is ignored.
- Arithmetic is unsigned, CNT_W bits. The counter never exceeds sz_q and never wraps.
- Index arithmetic is sized to CNT_W, with MAX_SZ <= 2^CNT_W-1.
- Latency: start to first valid index 0 with busy_o=1 is 1 cycle. A full traversal takes sz_q strobes plus 1 DONE cycle.
- Reset asserted mid-RUN: immediate return to the reset values, no done_o.

Optional Feature:
- Macro: AUX_CNT_STALL_STAT_EN.
- When defined: adds output stall_cnt_o (8 bits).
  - Counts RUN cycles with en_i=0 and saturates at 255.
  - Cleared to 0 on accepted start and on reset.
  - Held through DONE and IDLE until the next start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package aux_pkg holds: the state encoding constants (S_IDLE=0, S_RUN=1, S_DONE=2), CNT_W and MAX_SZ defaults, and STALL_W=8.
- One natural sub-module: aux_sat_cnt.
  - Generic CNT_W saturating up-counter with clear, enable and limit inputs.
  - Used for the index, and reused for stall_cnt_o when the macro is defined.
- State machine and start validation stay in aux_cnt_ctrl.

Test Plan:
- Reset, then start_i with sz_full_i=8 and en_i held high 8 cycles -> aux_reg_o steps 0..8; done_o high exactly one cycle while aux_reg_o=8; aux_reg_o=0 next cycle; busy_o high for 8 cycles.
- sz_full_i=32, en_i toggled 1,0,0,1… -> aux_reg_o advances only on en_i=1; done_o after the 32nd strobe. With the macro defined, stall_cnt_o equals the number of zero cycles.
- start_i with sz_full_i=0, then with sz_full_i=40 -> err_o one-cycle pulse each time; state stays IDLE; busy_o=0; aux_reg_o=0.
- RUN at aux_reg_o=5 with clr_i=1 and en_i=1 together -> next cycle IDLE, aux_reg_o=0, no done_o.
- RUN at aux_reg_o=3, start_i=1 with sz_full_i=4 -> ignored; traversal completes at the original size.
- rstn driven low asynchronously mid-cycle during RUN -> outputs reach reset values before the next clk edge; normal operation after release.
